mac_unit_simd: RTL and testbench

//  Parametrised, pipelined multi-lane int8 MAC processing element; successor to the single-lane PE.
//  Per beat: LANES signed products of (input+input_offset)*weight, summed by an adder tree.
//  The sum is added to a bias, the local accumulator, or a chained partial sum.

---
 rtl/mac_pkg.sv | 16 +
 rtl/mac_unit_simd_if.sv | 23 ++
 rtl/mac_adder_tree.sv | 19 +
 rtl/mac_unit_simd.sv | 78 +++++++
 tb/tb_mac_unit_simd.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: width derivations, base selection and clamp helper for the SIMD MAC
package mac_pkg;
  typedef enum logic [1:0] {BASE_BIAS, BASE_CHAIN, BASE_ACC} base_sel_e;
  function automatic int prod_w(input int data_w);
    return 2 * data_w + 2;
  endfunction
  function automatic int tree_w(input int data_w, input int lanes);
    return prod_w(data_w) + $clog2(lanes);
  endfunction
  // Clamps a sign-extended sum to the signed range of an acc_w-bit accumulator.
  function automatic logic signed [64:0] sat_acc(input logic signed [64:0] s, input int acc_w);
    logic signed [64:0] hi;
    hi = (65'sd1 <<< (acc_w - 1)) - 65'sd1;
    return s > hi ? hi : s < -hi - 65'sd1 ? -hi - 65'sd1 : s;
  endfunction
endpackage

// File: rtl/mac_unit_simd_if.sv
// mac_unit_simd_if: beat, control and result signals of the SIMD MAC
interface mac_unit_simd_if #(parameter int DATA_W = 8, parameter int LANES = 4, parameter int ACC_W = 32);
  logic clear;
  logic in_valid;
  logic load_bias;
  logic chain_mode;
  logic signed [DATA_W:0] input_offset;
  logic [LANES*DATA_W-1:0] input_data;
  logic [LANES*DATA_W-1:0] weight_data;
  logic signed [ACC_W-1:0] bias_in;
  logic signed [ACC_W-1:0] partial_sum_in;
  logic signed [ACC_W-1:0] partial_sum_out;
  logic output_valid;
  logic sat_flag;
  modport master (
    output clear, in_valid, load_bias, chain_mode, input_offset, input_data, weight_data, bias_in, partial_sum_in,
    input partial_sum_out, output_valid, sat_flag
  );
  modport slave (
    input clear, in_valid, load_bias, chain_mode, input_offset, input_data, weight_data, bias_in, partial_sum_in,
    output partial_sum_out, output_valid, sat_flag
  );
endinterface

// File: rtl/mac_adder_tree.sv
// mac_adder_tree: combinational balanced signed adder tree over packed lanes
module mac_adder_tree #(
  parameter int LANES = 4,
  parameter int IN_W = 18,
  localparam int OUT_W = IN_W + $clog2(LANES)
) (
  input  logic [LANES*IN_W-1:0] operands,
  output logic signed [OUT_W-1:0] sum
);
  // Heap layout: leaves at LANES..2*LANES-1, node k sums nodes 2k and 2k+1.
  logic signed [OUT_W-1:0] node [1:2*LANES-1];
  for (genvar i = 0; i < LANES; i++) begin : g_leaf
    assign node[LANES+i] = OUT_W'($signed(operands[i*IN_W +: IN_W]));
  end
  for (genvar i = 1; i < LANES; i++) begin : g_node
    assign node[i] = node[2*i] + node[2*i+1];
  end
  assign sum = node[1];
endmodule

// File: rtl/mac_unit_simd.sv
// mac_unit_simd: two-stage multi-lane int8 MAC with bias/chain base and optional saturation
module mac_unit_simd
  import mac_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LANES = 4,
  parameter int ACC_W = 32,
  parameter int SATURATE = 1
) (
  input logic clk,
  input logic reset,
  mac_unit_simd_if.slave bus
);
  localparam int PROD_W = prod_w(DATA_W);
  localparam int TREE_W = tree_w(DATA_W, LANES);
  logic [LANES*PROD_W-1:0] prod_c, s1_prod;
  logic fire, s1_valid, s1_load, s1_chain, out_valid, sat_q, sat_hit;
  logic signed [ACC_W-1:0] s1_bias, s1_psum, acc, base, nxt;
  logic signed [TREE_W-1:0] tree;
  logic signed [ACC_W:0] sum;
  logic signed [64:0] sum_x, clamped;
  base_sel_e sel;
  assign fire = bus.in_valid | bus.load_bias;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [DATA_W+1:0] x;
    logic signed [PROD_W-1:0] p;
    assign x = (DATA_W+2)'($signed(bus.input_data[i*DATA_W +: DATA_W])) + (DATA_W+2)'(bus.input_offset);
    assign p = PROD_W'(x) * PROD_W'($signed(bus.weight_data[i*DATA_W +: DATA_W]));
    assign prod_c[i*PROD_W +: PROD_W] = bus.in_valid ? p : '0;
  end
  mac_adder_tree #(.LANES(LANES), .IN_W(PROD_W)) u_tree (.operands(s1_prod), .sum(tree));
  always_comb begin
    sel = s1_load ? BASE_BIAS : s1_chain ? BASE_CHAIN : BASE_ACC;
    base = sel == BASE_BIAS ? s1_bias : sel == BASE_CHAIN ? s1_psum : acc;
    sum = (ACC_W+1)'(base) + (ACC_W+1)'(tree);
    sum_x = 65'(sum);
    clamped = sat_acc(sum_x, ACC_W);
    sat_hit = SATURATE != 0 && clamped != sum_x;
    nxt = SATURATE != 0 ? clamped[ACC_W-1:0] : sum[ACC_W-1:0];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_load <= 1'b0;
      s1_chain <= 1'b0;
      s1_bias <= '0;
      s1_psum <= '0;
      s1_prod <= '0;
    end else if (bus.clear) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= fire;
      if (fire) begin
        s1_load <= bus.load_bias;
        s1_chain <= bus.chain_mode;
        s1_bias <= bus.bias_in;
        s1_psum <= bus.partial_sum_in;
        s1_prod <= prod_c;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset || bus.clear) begin
      acc <= '0;
      out_valid <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        acc <= nxt;
        sat_q <= sat_q | sat_hit;
      end
    end
  end
  assign bus.partial_sum_out = acc;
  assign bus.output_valid = out_valid;
  assign bus.sat_flag = sat_q;
endmodule

// File: tb/tb_mac_unit_simd.sv
// tb_mac_unit_simd: directed scoreboard bench for saturating and wrapping MAC instances
module tb_mac_unit_simd;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;
  typedef struct {
    int unsigned due;
    logic [31:0] sat;
    logic flag;
    logic [31:0] wrap;
  } exp_t;
  logic clk = 1'b0;
  logic reset;
  int tests = 0;
  int fails = 0;
  int unsigned cyc = 0;
  exp_t q[$];
  longint m_sat = 0;
  longint m_wrap = 0;
  logic m_flag = 1'b0;
  mac_unit_simd_if #(.DATA_W(8), .LANES(4), .ACC_W(32)) bs ();
  mac_unit_simd_if #(.DATA_W(8), .LANES(4), .ACC_W(32)) bw ();
  mac_unit_simd #(.DATA_W(8), .LANES(4), .ACC_W(32), .SATURATE(1)) u_sat (.clk(clk), .reset(reset), .bus(bs.slave));
  mac_unit_simd #(.DATA_W(8), .LANES(4), .ACC_W(32), .SATURATE(0)) u_wrap (.clk(clk), .reset(reset), .bus(bw.slave));
  always #5 clk = ~clk;

  function automatic logic [31:0] p4(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic observe();
    if (q.size() != 0 && q[0].due == cyc) begin
      exp_t e;
      e = q.pop_front();
      chk("valid_sat", {31'b0, bs.output_valid}, 32'd1);
      chk("acc_sat", bs.partial_sum_out, e.sat);
      chk("flag_sat", {31'b0, bs.sat_flag}, {31'b0, e.flag});
      chk("valid_wrap", {31'b0, bw.output_valid}, 32'd1);
      chk("acc_wrap", bw.partial_sum_out, e.wrap);
      chk("flag_wrap", {31'b0, bw.sat_flag}, 32'd0);
    end else begin
      chk("idle_valid_sat", {31'b0, bs.output_valid}, 32'd0);
      chk("idle_valid_wrap", {31'b0, bw.output_valid}, 32'd0);
    end
  endtask

  task automatic put(input logic clr, input logic iv, input logic lb, input logic ch, input int off,
                     input logic [31:0] ind, input logic [31:0] wd, input int bias, input int psum);
    bs.clear = clr; bw.clear = clr;
    bs.in_valid = iv; bw.in_valid = iv;
    bs.load_bias = lb; bw.load_bias = lb;
    bs.chain_mode = ch; bw.chain_mode = ch;
    bs.input_offset = 9'(off); bw.input_offset = 9'(off);
    bs.input_data = ind; bw.input_data = ind;
    bs.weight_data = wd; bw.weight_data = wd;
    bs.bias_in = bias; bw.bias_in = bias;
    bs.partial_sum_in = psum; bw.partial_sum_in = psum;
  endtask

  task automatic drive(input logic clr, input logic iv, input logic lb, input logic ch, input int off,
                       input logic [31:0] ind, input logic [31:0] wd, input int bias, input int psum);
    longint t, s;
    @(negedge clk);
    cyc++;
    observe();
    put(clr, iv, lb, ch, off, ind, wd, bias, psum);
    if (clr) begin
      q.delete();
      m_sat = 0;
      m_wrap = 0;
      m_flag = 1'b0;
    end else if (iv || lb) begin
      t = 0;
      if (iv) for (int i = 0; i < 4; i++)
        t += longint'((int'(byte'(ind[8*i +: 8])) + off) * int'(byte'(wd[8*i +: 8])));
      s = (lb ? longint'(bias) : ch ? longint'(psum) : m_sat) + t;
      if (s > MAXV) begin s = MAXV; m_flag = 1'b1; end
      else if (s < MINV) begin s = MINV; m_flag = 1'b1; end
      m_sat = s;
      m_wrap = longint'(int'((lb ? longint'(bias) : ch ? longint'(psum) : m_wrap) + t));
      q.push_back('{cyc + 2, m_sat[31:0], m_flag, m_wrap[31:0]});
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 32'd0, 32'd0, 0, 0);
  endtask

  initial begin
    reset = 1'b0;
    put(1'b0, 1'b0, 1'b0, 1'b0, 0, 32'd0, 32'd0, 0, 0);
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_acc", bs.partial_sum_out, 32'd0);
    chk("reset_valid", {31'b0, bs.output_valid}, 32'd0);
    chk("reset_flag", {31'b0, bs.sat_flag}, 32'd0);
    reset = 1'b0;
    // bias then accumulate
    drive(1'b0, 1'b1, 1'b1, 1'b0, 0, p4(1, 2, 3, 4), p4(1, 1, 1, 1), 10, 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 0, p4(1, 2, 3, 4), p4(1, 1, 1, 1), 0, 0);
    idle(); idle();
    // zero-point offset cancels the inputs, then plain accumulate
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 32'd0, 32'd0, 0, 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 128, p4(-128, -128, -128, -128), p4(5, 5, 5, 5), 0, 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 0, p4(-128, -128, -128, -128), p4(5, 5, 5, 5), 0, 0);
    idle(); idle();
    // positive overflow: clamp vs wrap, then clear
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 32'd0, 32'd0, 0, 0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 0, p4(127, 127, 127, 127), p4(127, 127, 127, 127), 'h7FFFFF00, 0);
    idle(); idle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 32'd0, 32'd0, 0, 0);
    idle();
    chk("clear_acc", bs.partial_sum_out, 32'd0);
    chk("clear_flag", {31'b0, bs.sat_flag}, 32'd0);
    // negative overflow
    drive(1'b0, 1'b1, 1'b1, 1'b0, 0, p4(-128, -128, -128, -128), p4(127, 127, 127, 127), int'(32'h80000100), 0);
    idle(); idle();
    // chained partial sums ignore the local accumulator
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 32'd0, 32'd0, 0, 0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 0, p4(1, 2, 3, 4), p4(1, 1, 1, 1), 500, 0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 0, p4(-1, -1, -1, -1), p4(3, 3, 3, 3), 0, 1000);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 0, p4(-1, -1, -1, -1), p4(3, 3, 3, 3), 0, 0);
    idle(); idle();
    // bias-only beat, then back-to-back restarts
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0, p4(9, 9, 9, 9), p4(9, 9, 9, 9), 77, 0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 0, p4(1, 2, 3, 4), p4(1, 1, 1, 1), 5, 0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 0, p4(1, 2, 3, 4), p4(1, 1, 1, 1), 7, 0);
    idle(); idle();
    // clear concurrent with a beat drops it and the one in flight
    drive(1'b0, 1'b1, 1'b0, 1'b0, 0, p4(1, 2, 3, 4), p4(1, 1, 1, 1), 0, 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 0, p4(4, 4, 4, 4), p4(4, 4, 4, 4), 0, 0);
    idle(); idle(); idle();
    chk("drop_acc", bs.partial_sum_out, 32'd0);
    // continuous stream, then async reset with beats in flight
    for (int k = 0; k < 8; k++)
      drive(1'b0, 1'b1, k == 0 || k == 5, k == 3, int'($urandom_range(40)) - 20, $urandom, $urandom,
            int'($urandom), int'($urandom));
    idle();
    #2 reset = 1'b1;
    #1;
    chk("rst_acc_sat", bs.partial_sum_out, 32'd0);
    chk("rst_acc_wrap", bw.partial_sum_out, 32'd0);
    chk("rst_valid", {31'b0, bs.output_valid}, 32'd0);
    chk("rst_flag", {31'b0, bs.sat_flag}, 32'd0);
    q.delete();
    m_sat = 0;
    m_wrap = 0;
    m_flag = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 0, p4(1, 2, 3, 4), p4(1, 1, 1, 1), 0, 0);
    idle(); idle(); idle();
    chk("drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
